// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the LEGv8 multicycle control unit.
//   - state_t   : control FSM states
//   - opclass_t : instruction class produced by the opcode decoder
//   - ALU_*     : 4-bit ALU operation codes driven on ALUControl
//   - SRCB_*    : ALUSrcB operand-select encodings
//   - OP_*      : opcode match constants for IR[31:21]
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_CB_EX,
    S_B_EX,
    S_ILLEGAL
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_LOAD,
    CL_STORE,
    CL_CBZ,
    CL_CBNZ,
    CL_B,
    CL_ILLEGAL
  } opclass_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // Branch opcodes only match on their leading bits; the rest is immediate.
  localparam logic [7:0]  OP_CBZ_PFX  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ_PFX = 8'b10110101;
  localparam logic [5:0]  OP_B_PFX    = 6'b000101;

endpackage

// File: rtl/mc_opdecode.sv
// mc_opdecode: combinational opcode decoder for the multicycle control unit.
// Ports:
//   Op    in  11 : opcode field IR[31:21]
//   cls   out    : instruction class (CL_ILLEGAL when nothing matches)
//   aluop out 4  : ALU operation for R-type instructions (ADD otherwise)
// Build option: MC_CBNZ_EN makes the CBNZ opcode decode as CL_CBNZ instead
// of falling through to CL_ILLEGAL.
module mc_opdecode
  import mc_pkg::*;
(
  input  logic [10:0] Op,
  output opclass_t    cls,
  output logic [3:0]  aluop
);

  always_comb begin
    cls   = CL_ILLEGAL;
    aluop = ALU_ADD;
    if (Op == OP_ADD) begin
      cls   = CL_RTYPE;
      aluop = ALU_ADD;
    end else if (Op == OP_SUB) begin
      cls   = CL_RTYPE;
      aluop = ALU_SUB;
    end else if (Op == OP_AND) begin
      cls   = CL_RTYPE;
      aluop = ALU_AND;
    end else if (Op == OP_ORR) begin
      cls   = CL_RTYPE;
      aluop = ALU_ORR;
    end else if (Op == OP_LDUR) begin
      cls = CL_LOAD;
    end else if (Op == OP_STUR) begin
      cls = CL_STORE;
    end else if (Op[10:3] == OP_CBZ_PFX) begin
      cls = CL_CBZ;
`ifdef MC_CBNZ_EN
    end else if (Op[10:3] == OP_CBNZ_PFX) begin
      cls = CL_CBNZ;
`endif
    end else if (Op[10:5] == OP_B_PFX) begin
      cls = CL_B;
    end
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: Moore control FSM for the LEGv8 multicycle datapath.
// Sequences FETCH -> DECODE -> execute/memory/write-back states and drives
// the ALU operation and operand selects, datapath strobes and Illegal.
// Ports:
//   clk, reset (async, active-high)
//   Op[10:0]     : IR[31:21], only looked at in DECODE
//   zero         : ALU zero flag, only looked at in CB_EX
//   mem_ready    : memory handshake, only looked at in FETCH/MEM_RD/MEM_WR
//   ALUControl[3:0], ALUSrcA, ALUSrcB[1:0], PCSrc : ALU / PC selects
//   PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc : strobes
//   Illegal      : FSM is parked in the ILLEGAL state
// Build option: MC_CBNZ_EN enables CBNZ (branch when zero is low).
module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        PCSrc,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        Reg2Loc,
  output logic        Illegal
);

  state_t     state, state_nxt;
  opclass_t   dec_cls, cls_r;
  logic [3:0] dec_aluop, aluop_r;

  mc_opdecode u_opdecode (
    .Op    (Op),
    .cls   (dec_cls),
    .aluop (dec_aluop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      cls_r <= CL_ILLEGAL;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) cls_r <= dec_cls;
    end
  end

  // ALU op is pure datapath information; it is always written in DECODE
  // before any state that reads it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) aluop_r <= dec_aluop;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (dec_cls)
          CL_RTYPE:          state_nxt = S_EXEC_R;
          CL_LOAD, CL_STORE: state_nxt = S_MEM_ADDR;
          CL_CBZ, CL_CBNZ:   state_nxt = S_CB_EX;
          CL_B:              state_nxt = S_B_EX;
          default:           state_nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   state_nxt = S_ALU_WB;
      S_ALU_WB:   state_nxt = S_FETCH;
      S_MEM_ADDR: state_nxt = (cls_r == CL_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_CB_EX:    state_nxt = S_FETCH;
      S_B_EX:     state_nxt = S_FETCH;
      S_ILLEGAL:  state_nxt = S_ILLEGAL;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // The state register already sits in FETCH during reset, but FETCH drives
  // MemRead; the reset term masks every output back to its idle value.
  always_comb begin
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    Reg2Loc    = 1'b0;
    Illegal    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          // Speculatively form the branch target into ALUOut.
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          Reg2Loc = (dec_cls == CL_STORE) || (dec_cls == CL_CBZ) ||
                    (dec_cls == CL_CBNZ);
        end
        S_EXEC_R: begin
          ALUSrcB    = SRCB_REG;
          ALUControl = aluop_r;
        end
        S_ALU_WB: RegWrite = 1'b1;
        S_MEM_ADDR: ALUSrcB = SRCB_IMM;
        S_MEM_RD: MemRead = 1'b1;
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          Reg2Loc  = 1'b1;
        end
        S_CB_EX: begin
          ALUSrcB    = SRCB_REG;
          ALUControl = ALU_PASSB;
          Reg2Loc    = 1'b1;
          PCSrc      = 1'b1;
          PCWrite    = (cls_r == CL_CBNZ) ? ~zero : zero;
        end
        S_B_EX: begin
          PCSrc   = 1'b1;
          PCWrite = 1'b1;
        end
        S_ILLEGAL: Illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control. Output vectors are packed as
// {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc, PCSrc,
//  ALUSrcA, ALUSrcB[1:0], ALUControl[3:0], Illegal}.
module tb_mc_control;
  import mc_pkg::*;

  logic        clk, reset, zero, mem_ready;
  logic [10:0] Op;
  logic [3:0]  ALUControl;
  logic [1:0]  ALUSrcB;
  logic        ALUSrcA, PCSrc, PCWrite, IRWrite, MemRead, MemWrite;
  logic        RegWrite, MemtoReg, Reg2Loc, Illegal;
  logic [15:0] obs;

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] O_RST     = 16'b0_0_0_0_0_0_0_0_0_00_0010_0;
  localparam logic [15:0] O_FETCH   = 16'b1_1_1_0_0_0_0_0_1_10_0010_0;
  localparam logic [15:0] O_FSTALL  = 16'b0_0_1_0_0_0_0_0_1_10_0010_0;
  localparam logic [15:0] O_DEC     = 16'b0_0_0_0_0_0_0_0_1_01_0010_0;
  localparam logic [15:0] O_DEC_R2L = 16'b0_0_0_0_0_0_1_0_1_01_0010_0;
  localparam logic [15:0] O_ALUWB   = 16'b0_0_0_0_1_0_0_0_0_00_0010_0;
  localparam logic [15:0] O_MADDR   = 16'b0_0_0_0_0_0_0_0_0_01_0010_0;
  localparam logic [15:0] O_MRD     = 16'b0_0_1_0_0_0_0_0_0_00_0010_0;
  localparam logic [15:0] O_MWB     = 16'b0_0_0_0_1_1_0_0_0_00_0010_0;
  localparam logic [15:0] O_MWR     = 16'b0_0_0_1_0_0_1_0_0_00_0010_0;
  localparam logic [15:0] O_CB_T    = 16'b1_0_0_0_0_0_1_1_0_00_0111_0;
  localparam logic [15:0] O_CB_N    = 16'b0_0_0_0_0_0_1_1_0_00_0111_0;
  localparam logic [15:0] O_BEX     = 16'b1_0_0_0_0_0_0_1_0_00_0010_0;
  localparam logic [15:0] O_ILL     = 16'b0_0_0_0_0_0_0_0_0_00_0010_1;

  mc_control dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .Reg2Loc    (Reg2Loc),
    .Illegal    (Illegal)
  );

  assign obs = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg,
                Reg2Loc, PCSrc, ALUSrcA, ALUSrcB, ALUControl, Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Op = 11'd0; zero = 1'b0; mem_ready = 1'b1;
    #3;
    checks++;
    if (obs !== O_RST) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs, O_RST);
    end
    checks++;
    if (dut.state !== S_FETCH) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dut.state, S_FETCH);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    #1;
    checks++;
    if (obs !== O_FSTALL || dut.state !== S_FETCH) begin
      errors++;
      $display("FAIL reset_release: got %b st %0d want %b st %0d",
               obs, dut.state, O_FSTALL, S_FETCH);
    end
  endtask

  task automatic test_rtype();
    logic [10:0] ops [4] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR};
    logic [3:0]  alu [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    state_t      es  [4] = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB};
    logic [15:0] eo  [4];
    tick();
    for (int k = 0; k < 4; k++) begin
      eo = '{O_FETCH, O_DEC, {12'b0, alu[k]} << 1, O_ALUWB};
      for (int i = 0; i < 4; i++) begin
        Op = ops[k]; mem_ready = 1'b1; zero = i[0];
        #1;
        checks++;
        if (obs !== eo[i] || dut.state !== es[i]) begin
          errors++;
          $display("FAIL rtype%0d_cyc%0d: got %b st %0d want %b st %0d",
                   k, i, obs, dut.state, eo[i], es[i]);
        end
        tick();
      end
      checks++;
      if (dut.state !== S_FETCH) begin
        errors++;
        $display("FAIL rtype%0d_return: got st %0d want %0d", k, dut.state, S_FETCH);
      end
    end
  endtask

  task automatic test_ldur_stall();
    logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    state_t      es  [7] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD,
                             S_MEM_RD, S_MEM_RD, S_MEM_WB};
    logic [15:0] eo  [7] = '{O_FETCH, O_DEC, O_MADDR, O_MRD, O_MRD, O_MRD, O_MWB};
    for (int i = 0; i < 7; i++) begin
      Op = OP_LDUR; mem_ready = rdy[i]; zero = 1'b0;
      #1;
      checks++;
      if (obs !== eo[i] || dut.state !== es[i]) begin
        errors++;
        $display("FAIL ldur_cyc%0d: got %b st %0d want %b st %0d",
                 i, obs, dut.state, eo[i], es[i]);
      end
      tick();
    end
    checks++;
    if (dut.state !== S_FETCH) begin
      errors++;
      $display("FAIL ldur_return: got st %0d want %0d", dut.state, S_FETCH);
    end
  endtask

  task automatic test_stur_fetch_stall();
    logic        rdy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    state_t      es  [5] = '{S_FETCH, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR};
    logic [15:0] eo  [5] = '{O_FSTALL, O_FETCH, O_DEC_R2L, O_MADDR, O_MWR};
    for (int i = 0; i < 5; i++) begin
      Op = OP_STUR; mem_ready = rdy[i]; zero = 1'b1;
      #1;
      checks++;
      if (obs !== eo[i] || dut.state !== es[i]) begin
        errors++;
        $display("FAIL stur_cyc%0d: got %b st %0d want %b st %0d",
                 i, obs, dut.state, eo[i], es[i]);
      end
      tick();
    end
    checks++;
    if (dut.state !== S_FETCH) begin
      errors++;
      $display("FAIL stur_return: got st %0d want %0d", dut.state, S_FETCH);
    end
  endtask

  task automatic test_branches();
    logic [10:0] ops [3] = '{11'b10110100101, 11'b10110100011, 11'b00010110011};
    logic        zv  [3] = '{1'b1, 1'b0, 1'b0};
    logic [15:0] e_dec [3] = '{O_DEC_R2L, O_DEC_R2L, O_DEC};
    logic [15:0] e_ex  [3] = '{O_CB_T, O_CB_N, O_BEX};
    state_t      s_ex  [3] = '{S_CB_EX, S_CB_EX, S_B_EX};
    logic [15:0] eo [3];
    state_t      es [3];
    for (int k = 0; k < 3; k++) begin
      eo = '{O_FETCH, e_dec[k], e_ex[k]};
      es = '{S_FETCH, S_DECODE, s_ex[k]};
      for (int i = 0; i < 3; i++) begin
        Op = ops[k]; mem_ready = 1'b1;
        // zero is only meaningful in the execute cycle.
        zero = (i == 2) ? zv[k] : ~zv[k];
        #1;
        checks++;
        if (obs !== eo[i] || dut.state !== es[i]) begin
          errors++;
          $display("FAIL branch%0d_cyc%0d: got %b st %0d want %b st %0d",
                   k, i, obs, dut.state, eo[i], es[i]);
        end
        tick();
      end
    end
    checks++;
    if (dut.state !== S_FETCH) begin
      errors++;
      $display("FAIL branch_return: got st %0d want %0d", dut.state, S_FETCH);
    end
  endtask

  task automatic test_illegal();
    Op = 11'b11111111111; mem_ready = 1'b1; zero = 1'b0;
    #1;
    tick();
    checks++;
    if (obs !== O_DEC || dut.state !== S_DECODE) begin
      errors++;
      $display("FAIL illegal_decode: got %b st %0d want %b", obs, dut.state, O_DEC);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; zero = i[1]; Op = OP_ADD;
      #1;
      checks++;
      if (obs !== O_ILL || dut.state !== S_ILLEGAL) begin
        errors++;
        $display("FAIL illegal_hold%0d: got %b st %0d want %b", i, obs, dut.state, O_ILL);
      end
      tick();
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== O_RST || dut.state !== S_FETCH) begin
      errors++;
      $display("FAIL illegal_reset: got %b st %0d want %b", obs, dut.state, O_RST);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    #1;
    checks++;
    if (obs !== O_FSTALL || dut.state !== S_FETCH) begin
      errors++;
      $display("FAIL illegal_release: got %b st %0d want %b", obs, dut.state, O_FSTALL);
    end
  endtask

  task automatic test_reset_mem_wr();
    Op = OP_STUR; mem_ready = 1'b1; zero = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();
    #1;
    checks++;
    if (obs !== O_MWR || dut.state !== S_MEM_WR) begin
      errors++;
      $display("FAIL memwr_stall: got %b st %0d want %b", obs, dut.state, O_MWR);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || obs !== O_RST || dut.state !== S_FETCH) begin
      errors++;
      $display("FAIL memwr_reset: got %b st %0d want %b", obs, dut.state, O_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    #1;
    checks++;
    if (obs !== O_FSTALL || dut.state !== S_FETCH) begin
      errors++;
      $display("FAIL memwr_release: got %b st %0d want %b", obs, dut.state, O_FSTALL);
    end
  endtask

  task automatic test_cbnz();
    logic [15:0] e_ex;
    state_t      s_ex;
`ifdef MC_CBNZ_EN
    e_ex = O_CB_T; s_ex = S_CB_EX;
`else
    e_ex = O_ILL;  s_ex = S_ILLEGAL;
`endif
    Op = 11'b10110101110; mem_ready = 1'b1; zero = 1'b0;
    tick();
    #1;
    checks++;
    if (dut.state !== S_DECODE) begin
      errors++;
      $display("FAIL cbnz_decode: got st %0d want %0d", dut.state, S_DECODE);
    end
    tick();
    #1;
    checks++;
    if (obs !== e_ex || dut.state !== s_ex) begin
      errors++;
      $display("FAIL cbnz_exec: got %b st %0d want %b st %0d", obs, dut.state, e_ex, s_ex);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_ldur_stall();
    test_stur_fetch_stall();
    test_branches();
    test_illegal();
    test_reset_mem_wr();
    test_cbnz();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
